regfile_wb_ctrl: RTL

//  Initiator side of the 32x32 register file write/read-check interface. Merges the

---
 rtl/regfile_wb_ctrl_pkg.sv | 16 +
 rtl/regfile_wb_ctrl_wb_fifo.sv | 55 +++++
 rtl/regfile_wb_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Covers widths, the hard-wired zero register and the queued-load entry layout.
package regfile_wb_ctrl_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int LQ_DEPTH   = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = REG_ADDR_W + XLEN;
endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Synchronous FIFO holding load writebacks until the register-file port is free.
// Depth must be a power of two so that the pointers wrap on their own.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Entry storage; stale contents are harmless because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Merges ALU and load writebacks onto the single register-file write port and keeps
// a per-register pending-write scoreboard for decode hazard checks.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  alu_wb_valid,
  input  logic [REG_ADDR_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]       alu_wb_data,
  input  logic                  mem_wb_valid,
  output logic                  mem_wb_ready,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]       mem_wb_data,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]       rf_write_data
);
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                fifo_pop_s;
  wb_entry_t           fifo_head_s;
  wb_entry_t           push_entry_s;
  wb_entry_t           sel_s;
  logic                sel_valid_s;
  logic                write_s;

  assign push_entry_s = '{rd: mem_wb_rd, data: mem_wb_data};
  assign mem_wb_ready = ~fifo_full_s;
  assign fifo_pop_s   = ~alu_wb_valid & ~fifo_empty_s;
  assign issue_ready  = (issue_rd == REG_ZERO) | ~busy_r[issue_rd];
  assign rs1_busy     = (rs1 != REG_ZERO) & busy_r[rs1];
  assign rs2_busy     = (rs2 != REG_ZERO) & busy_r[rs2];

  wb_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_wb_valid),
    .push_data (push_entry_s),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // ALU always wins the port; queued loads only drain on ALU-idle cycles.
  always_comb begin
    sel_s       = '{rd: REG_ZERO, data: {XLEN{1'b0}}};
    sel_valid_s = 1'b0;
    if (alu_wb_valid) begin
      sel_s       = '{rd: alu_wb_rd, data: alu_wb_data};
      sel_valid_s = 1'b1;
    end else if (!fifo_empty_s) begin
      sel_s       = fifo_head_s;
      sel_valid_s = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
    end
    write_s = sel_valid_s & (sel_s.rd != REG_ZERO);
  end

  // Clear on write and set on accepted issue can never collide on one register.
  always_comb begin
    busy_next_s = busy_r;
    if (write_s) begin
      busy_next_s[sel_s.rd] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (issue_valid && issue_ready && (issue_rd != REG_ZERO)) begin
      busy_next_s[issue_rd] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Scoreboard and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r          <= {NUM_REGS{1'b0}};
      rf_write_enable <= 1'b0;
      rf_write_reg    <= REG_ZERO;
      rf_write_data   <= {XLEN{1'b0}};
    end else begin
      busy_r          <= busy_next_s;
      rf_write_enable <= write_s;
      if (write_s) begin
        rf_write_reg  <= sel_s.rd;
        rf_write_data <= sel_s.data;
      end
    end
  end
endmodule
